// File: rtl/d_reg_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : d_reg_pipe_pkg
// Brief    : Shared helpers for the d_reg_pipe register pipeline: occupancy
//            counter width and parameter legality checks.
// Revision : 1.0 - initial release
// ============================================================================
package d_reg_pipe_pkg;

    // Width of the occupancy count for a pipe of the given depth (min 1 bit).
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // A pipe needs at least one register stage.
    function automatic bit depth_ok(input int depth);
        return depth >= 1;
    endfunction

    // The payload must carry at least one bit.
    function automatic bit width_ok(input int width);
        return width >= 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_reg_stage.sv
`default_nettype none
// ============================================================================
// Module   : d_reg_stage
// Brief    : One pipeline stage: valid bit plus WIDTH-bit data register with
//            load/unload control, flush-to-RESET_VAL and synchronous
//            active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module d_reg_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] d,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q
);

    logic             valid_d;
    logic [WIDTH-1:0] data_d;

    // Next state: flush wins, a word moving in refills, a word moving out empties.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = RESET_VAL;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = d;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/d_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : d_reg_pipe
// Brief    : DEPTH-stage valid/ready register pipeline with bubble collapse
//            and synchronous flush. Optional occupancy port enabled by the
//            D_REG_PIPE_OCC_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module d_reg_pipe
    import d_reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush
`ifdef D_REG_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occ
`endif
);

    if (!depth_ok(DEPTH)) begin : g_chk_depth
        $error("d_reg_pipe: DEPTH must be at least 1");
    end
    if (!width_ok(WIDTH)) begin : g_chk_width
        $error("d_reg_pipe: WIDTH must be at least 1");
    end

    logic [DEPTH-1:0] stage_valid;
    logic [DEPTH-1:0] stage_load;
    logic [DEPTH-1:0] stage_unload;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             push;

    // Ready chain rippling back from out_ready; a stage may advance when the
    // next one is empty or itself advancing, which closes up bubbles.
    always_comb begin
        adv          = '0;
        stage_load   = '0;
        stage_unload = '0;
        adv[DEPTH-1] = out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            adv[k] = !stage_valid[k+1] || adv[k+1];
        end
        in_ready  = (!stage_valid[0] || adv[0]) && !flush;
        out_valid = stage_valid[DEPTH-1] && !flush;
        push      = in_valid && in_ready;
        stage_load[0] = push;
        for (int k = 1; k < DEPTH; k++) begin
            stage_load[k] = stage_valid[k-1] && adv[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            stage_unload[k] = stage_valid[k] && adv[k];
        end
    end

    assign out_data = stage_data[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] stage_in;
        if (k == 0) begin : g_head
            assign stage_in = in_data;
        end else begin : g_body
            assign stage_in = stage_data[k-1];
        end

        d_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush   (flush),
            .load    (stage_load[k]),
            .unload  (stage_unload[k]),
            .d       (stage_in),
            .valid_q (stage_valid[k]),
            .data_q  (stage_data[k])
        );
    end

`ifdef D_REG_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             pop;

    // Occupancy tracks transfers on both sides; flush empties it.
    always_comb begin
        pop   = out_valid && out_ready;
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Occupancy register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_d_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_d_reg_pipe
// Brief    : Self-checking bench for d_reg_pipe (WIDTH=8, DEPTH=3,
//            RESET_VAL=8'hA5) against a queue-based model of word positions.
//            Checks occ only when D_REG_PIPE_OCC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_d_reg_pipe;

    localparam int         WIDTH     = 8;
    localparam int         DEPTH     = 3;
    localparam logic [7:0] RESET_VAL = 8'hA5;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
`ifdef D_REG_PIPE_OCC_EN
    logic [d_reg_pipe_pkg::occ_width(DEPTH)-1:0] occ;
`endif

    d_reg_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush)
`ifdef D_REG_PIPE_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words in FIFO order (oldest first) with their stage
    // position, plus the data word last seen in the output stage.
    typedef struct {
        logic [7:0] data;
        int         pos;
    } ent_t;

    ent_t       q[$];
    logic [7:0] last_data;
    bit         model_live;
    int         n_checks;
    int         n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, clock,
    // then advance the model by the pipeline's transfer rules.
    task automatic step(input logic rst_n, input logic fl, input logic iv,
                        input logic [7:0] id, input logic ordy);
        bit exp_ir;
        bit exp_ov;
        bit stuck_run;
        int expect_pos;
        @(negedge clk);
        reset     = rst_n;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        // Stage 0 is blocked only when every stage holds a word and nothing drains.
        exp_ir = !fl && ((q.size() < DEPTH) || ordy);
        exp_ov = !fl && (q.size() > 0) && (q[0].pos == DEPTH - 1);
        if (model_live) begin
            check("in_ready", 32'(in_ready), 32'(exp_ir));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("out_data", 32'(out_data), 32'(last_data));
`ifdef D_REG_PIPE_OCC_EN
            check("occ", 32'(occ), 32'(q.size()));
`endif
        end
        @(posedge clk);
        if (!rst_n || fl) begin
            q.delete();
            last_data  = RESET_VAL;
            if (!rst_n) model_live = 1'b1;
        end else begin
            // Words pinned behind a stalled output form a contiguous run from
            // the last stage; everything else moves up one stage.
            stuck_run  = !ordy;
            expect_pos = DEPTH - 1;
            for (int i = 0; i < q.size(); i++) begin
                if (stuck_run && q[i].pos == expect_pos) begin
                    expect_pos--;
                end else begin
                    stuck_run = 1'b0;
                    q[i].pos++;
                end
            end
            if (q.size() > 0 && q[0].pos == DEPTH) void'(q.pop_front());
            if (iv && exp_ir) q.push_back('{data: id, pos: 0});
            if (q.size() > 0 && q[0].pos == DEPTH - 1) last_data = q[0].data;
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        model_live = 1'b0;
        last_data  = RESET_VAL;
        reset      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;

        // Reset for two cycles, then observe the idle pipe.
        do_reset(2);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_out_data", 32'(out_data), 32'(RESET_VAL));

        // Streaming 01..10 back-to-back with out_ready high, then drain.
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Backpressure: fill, offer a 4th word, then push+pop together.
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h23, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h23, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Bubble collapse: A, two idle cycles, B, all with output stalled.
        do_reset(1);
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hBB, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Flush with two words held and a word offered in the flush cycle.
        do_reset(1);
        step(1'b1, 1'b0, 1'b1, 8'h31, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h32, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'h33, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("flush_out_data", 32'(out_data), 32'(RESET_VAL));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset while full with out_ready high, then one word through.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h4F, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h50, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) < 7),
                 8'($urandom),
                 ($urandom_range(0, 9) < 6));
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
